// File: rtl/llr_loader.sv
// llr_loader: streams one frame of channel LLRs into the external single-port RAM.
// Latency: an accepted beat appears on the ram_* write port on the following cycle (registered).
// Backpressure: in_ready is high only in LOAD; the loader blocks after FRAME_LEN beats until buf_release.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   start                 arms a frame load, honoured only in IDLE
//   buf_release           decoder is done with the buffer, honoured only in DONE
//                         ("release" is a reserved word in SystemVerilog, hence the prefix)
//   in_valid/in_ready     input sample handshake; in_data is a signed sample, in_last marks the frame end
//   ram_address/ram_data_in/ram_write_en/ram_chip_sel   EXT_RAM write port
//   busy                  high in LOAD or DONE
//   frame_done            one-cycle pulse on the first DONE cycle
//   len_err               sticky in_last framing error, cleared by the next accepted start
// Build option: define LLR_SAT_EN to clamp samples symmetrically instead of truncating them.
module llr_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int IN_WIDTH   = 10,
  parameter int FRAME_LEN  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  buf_release,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_last,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_write_en,
  output logic                  ram_chip_sel,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  len_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_BEAT = ADDR_WIDTH'(FRAME_LEN - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  len_err_q, len_err_d;
  logic [DATA_WIDTH-1:0] narrow_dat;
  logic                  beat;
  logic                  is_last;

  // Sample narrowing to the RAM word width.
`ifdef LLR_SAT_EN
  // Symmetric clamp: the most negative code is excluded so the stored range is +/-(2^(DW-1)-1).
  localparam logic signed [IN_WIDTH-1:0] SAT_HI = IN_WIDTH'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [IN_WIDTH-1:0] SAT_LO = -SAT_HI;

  always_comb begin
    narrow_dat = in_data[DATA_WIDTH-1:0];
    if ($signed(in_data) > SAT_HI) begin
      narrow_dat = SAT_HI[DATA_WIDTH-1:0];
    end else if ($signed(in_data) < SAT_LO) begin
      narrow_dat = SAT_LO[DATA_WIDTH-1:0];
    end
  end
`else
  // Plain truncation: upper sample bits are dropped.
  assign narrow_dat = in_data[DATA_WIDTH-1:0];

  if (IN_WIDTH > DATA_WIDTH) begin : g_trunc
    logic unused_hi;
    assign unused_hi = ^in_data[IN_WIDTH-1:DATA_WIDTH];
  end
`endif

  assign in_ready = (state_q == S_LOAD);
  assign beat     = in_valid && in_ready;
  assign is_last  = (cnt_q == LAST_BEAT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    len_err_d = len_err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          cnt_d     = '0;
          len_err_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (beat) begin
          addr_d = cnt_q;
          data_d = narrow_dat;
          we_d   = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          // Framing check only flags; the frame length is fixed by FRAME_LEN.
          if (in_last != is_last) begin
            len_err_d = 1'b1;
          end
          if (is_last) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        // buf_release wins over a simultaneous start; start must be re-issued in IDLE.
        if (buf_release) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      len_err_q <= len_err_d;
    end
  end

  assign ram_address  = addr_q;
  assign ram_data_in  = data_q;
  assign ram_write_en = we_q;
  assign ram_chip_sel = we_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign len_err      = len_err_q;

endmodule

// File: tb/tb_llr_loader.sv
module tb_llr_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       buf_release;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_data;
  logic       in_last;
  logic [7:0] ram_address;
  logic [7:0] ram_data_in;
  logic       ram_write_en;
  logic       ram_chip_sel;
  logic       busy;
  logic       frame_done;
  logic       len_err;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  logic [7:0] mem [256];

  llr_loader #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8),
    .IN_WIDTH  (10),
    .FRAME_LEN (256)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .buf_release (buf_release),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .ram_address (ram_address),
    .ram_data_in (ram_data_in),
    .ram_write_en(ram_write_en),
    .ram_chip_sel(ram_chip_sel),
    .busy        (busy),
    .frame_done  (frame_done),
    .len_err     (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External RAM write-port model.
  always @(posedge clk) begin
    if (ram_write_en && ram_chip_sel) mem[ram_address] <= ram_data_in;
  end

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
  end

  // Expected stored value for a small non-negative or negative integer sample.
  function automatic logic [7:0] exp_narrow(input int v);
    logic [31:0] t;
`ifdef LLR_SAT_EN
    if (v > 127) return 8'h7F;
    if (v < -127) return 8'h81;
`endif
    t = v;
    return t[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_beat(input int v, input logic last);
    in_valid = 1'b1;
    in_data  = 10'(v);
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Feeds beats until the loader leaves LOAD, then releases the buffer.
  task automatic finish_frame();
    int n = 0;
    while (in_ready === 1'b1 && n < 300) begin
      do_beat(n, 1'b0);
      n++;
    end
    if (in_ready !== 1'b0) begin fails++; $display("FAIL finish_frame timeout in_ready=%b", in_ready); end
    tests++;
    buf_release = 1'b1;
    tick();
    buf_release = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    if ({in_ready, ram_write_en, ram_chip_sel, busy, frame_done, len_err} !== 6'b0) begin
      fails++; $display("FAIL reset_ctl got=%b exp=000000", {in_ready, ram_write_en, ram_chip_sel, busy, frame_done, len_err});
    end
    tests++;
    if ({ram_address, ram_data_in} !== 16'h0000) begin
      fails++; $display("FAIL reset_ram got=%h exp=0000", {ram_address, ram_data_in});
    end
    tests++;
    rst_n = 1'b1;
    tick();
    if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy got=%b exp=0", busy); end
    tests++;
  endtask

  task automatic test_full_frame();
    done_cnt = 0;
    do_start();
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      fails++; $display("FAIL start_busy got=%b%b exp=11", busy, in_ready);
    end
    tests++;
    for (int k = 0; k < 256; k++) begin
      in_valid = 1'b1;
      in_data  = 10'(k);
      in_last  = (k == 255);
      tick();
      if (ram_write_en !== 1'b1 || ram_chip_sel !== 1'b1) begin
        fails++; $display("FAIL full_we k=%0d got=%b%b exp=11", k, ram_write_en, ram_chip_sel);
      end
      tests++;
      if (ram_address !== 8'(k)) begin
        fails++; $display("FAIL full_addr got=%0d exp=%0d", ram_address, k);
      end
      tests++;
      if (ram_data_in !== exp_narrow(k)) begin
        fails++; $display("FAIL full_data k=%0d got=%h exp=%h", k, ram_data_in, exp_narrow(k));
      end
      tests++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (frame_done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || len_err !== 1'b0) begin
      fails++; $display("FAIL full_end done/rdy/busy/err got=%b%b%b%b exp=1010", frame_done, in_ready, busy, len_err);
    end
    tests++;
    tick();
    if (frame_done !== 1'b0 || ram_write_en !== 1'b0) begin
      fails++; $display("FAIL full_post done/we got=%b%b exp=00", frame_done, ram_write_en);
    end
    tests++;
    tick();
    if (done_cnt !== 1) begin fails++; $display("FAIL full_done_cnt got=%0d exp=1", done_cnt); end
    tests++;
    for (int k = 0; k < 256; k++) begin
      if (mem[k] !== exp_narrow(k)) begin
        fails++; $display("FAIL readback addr=%0d got=%h exp=%h", k, mem[k], exp_narrow(k));
      end
      tests++;
    end
    buf_release = 1'b1;
    tick();
    buf_release = 1'b0;
    if (busy !== 1'b0) begin fails++; $display("FAIL release_busy got=%b exp=0", busy); end
    tests++;
  endtask

  task automatic test_narrowing();
    int         sin  [4] = '{300, -300, -128, 50};
`ifdef LLR_SAT_EN
    logic [7:0] sexp [4] = '{8'h7F, 8'h81, 8'h81, 8'h32};
`else
    logic [7:0] sexp [4] = '{8'h2C, 8'hD4, 8'h80, 8'h32};
`endif
    do_start();
    for (int i = 0; i < 4; i++) begin
      do_beat(sin[i], 1'b0);
      if (ram_data_in !== sexp[i]) begin
        fails++; $display("FAIL narrow in=%0d got=%h exp=%h", sin[i], ram_data_in, sexp[i]);
      end
      tests++;
    end
    finish_frame();
  endtask

  task automatic test_gapped();
    do_start();
    do_beat(5, 1'b0);
    if (ram_write_en !== 1'b1 || ram_address !== 8'd0) begin
      fails++; $display("FAIL gap_b0 we/addr got=%b/%0d exp=1/0", ram_write_en, ram_address);
    end
    tests++;
    tick();
    if (ram_write_en !== 1'b0 || ram_chip_sel !== 1'b0 || ram_address !== 8'd0) begin
      fails++; $display("FAIL gap_idle we/cs/addr got=%b%b/%0d exp=00/0", ram_write_en, ram_chip_sel, ram_address);
    end
    tests++;
    do_beat(6, 1'b0);
    if (ram_write_en !== 1'b1 || ram_address !== 8'd1 || ram_data_in !== 8'd6) begin
      fails++; $display("FAIL gap_b1 we/addr/data got=%b/%0d/%0d exp=1/1/6", ram_write_en, ram_address, ram_data_in);
    end
    tests++;
    tick();
    if (ram_write_en !== 1'b0 || ram_address !== 8'd1) begin
      fails++; $display("FAIL gap_idle2 we/addr got=%b/%0d exp=0/1", ram_write_en, ram_address);
    end
    tests++;
    for (int k = 2; k < 256; k++) do_beat(k, k == 255);
    in_valid = 1'b1;
    #1;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL done_ready got=%b exp=0", in_ready); end
    tests++;
    tick();
    tick();
    in_valid = 1'b0;
    if (ram_write_en !== 1'b0) begin fails++; $display("FAIL done_we got=%b exp=0", ram_write_en); end
    tests++;
    buf_release = 1'b1;
    tick();
    buf_release = 1'b0;
  endtask

  task automatic test_len_err();
    do_start();
    for (int k = 0; k < 256; k++) begin
      do_beat(k, k == 10);
      if (k == 9 && len_err !== 1'b0) begin fails++; $display("FAIL lerr_b9 got=%b exp=0", len_err); end
      if (k == 9) tests++;
      if (k == 10 && len_err !== 1'b1) begin fails++; $display("FAIL lerr_b10 got=%b exp=1", len_err); end
      if (k == 10) tests++;
    end
    if (frame_done !== 1'b1 || len_err !== 1'b1) begin
      fails++; $display("FAIL lerr_end done/err got=%b%b exp=11", frame_done, len_err);
    end
    tests++;
    buf_release = 1'b1;
    tick();
    buf_release = 1'b0;
    if (len_err !== 1'b1) begin fails++; $display("FAIL lerr_hold got=%b exp=1", len_err); end
    tests++;
    do_start();
    if (len_err !== 1'b0) begin fails++; $display("FAIL lerr_clear got=%b exp=0", len_err); end
    tests++;
    // Final beat without in_last is also a framing error.
    for (int k = 0; k < 255; k++) do_beat(k, 1'b0);
    if (len_err !== 1'b0) begin fails++; $display("FAIL lerr_pre_last got=%b exp=0", len_err); end
    tests++;
    do_beat(255, 1'b0);
    if (len_err !== 1'b1 || frame_done !== 1'b1) begin
      fails++; $display("FAIL lerr_nolast err/done got=%b%b exp=11", len_err, frame_done);
    end
    tests++;
    buf_release = 1'b1;
    tick();
    buf_release = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_start();
    for (int k = 0; k <= 100; k++) do_beat(k, 1'b0);
    done_cnt = 0;
    rst_n = 1'b0;
    #1;
    if ({in_ready, ram_write_en, ram_chip_sel, busy, frame_done, len_err, ram_address, ram_data_in} !== 22'b0) begin
      fails++; $display("FAIL midrst_out got=%b%b%b%b%b%b %h %h exp=all0", in_ready, ram_write_en, ram_chip_sel, busy, frame_done, len_err, ram_address, ram_data_in);
    end
    tests++;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    if (done_cnt !== 0 || busy !== 1'b0 || ram_write_en !== 1'b0) begin
      fails++; $display("FAIL midrst_after done_cnt/busy/we got=%0d/%b/%b exp=0/0/0", done_cnt, busy, ram_write_en);
    end
    tests++;
    do_start();
    do_beat(77, 1'b0);
    if (ram_address !== 8'd0 || ram_data_in !== 8'd77) begin
      fails++; $display("FAIL midrst_restart addr/data got=%0d/%0d exp=0/77", ram_address, ram_data_in);
    end
    tests++;
    finish_frame();
  endtask

  task automatic test_done_ctrl();
    do_start();
    for (int k = 0; k < 256; k++) do_beat(k, k == 255);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      fails++; $display("FAIL done_start busy/rdy got=%b%b exp=10", busy, in_ready);
    end
    tests++;
    start = 1'b1;
    buf_release = 1'b1;
    tick();
    start = 1'b0;
    buf_release = 1'b0;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL both busy/rdy got=%b%b exp=00", busy, in_ready);
    end
    tests++;
    tick();
    if (busy !== 1'b0) begin fails++; $display("FAIL idle_stay got=%b exp=0", busy); end
    tests++;
    do_start();
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      fails++; $display("FAIL restart busy/rdy got=%b%b exp=11", busy, in_ready);
    end
    tests++;
    finish_frame();
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    buf_release = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    test_reset();
    test_full_frame();
    test_narrowing();
    test_gapped();
    test_len_err();
    test_mid_reset();
    test_done_ctrl();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
